hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Hazard-detection and operand-forwarding controller for the 5-stage MIPS pipeline. Tracks destination-register tags of in-flight instructions in EX, MEM, WB and a one-entry retire stage (RET). Detects load-use hazards against the instruction in ID and drives the 2-bit selects of the two 32-bit EX-stage operand muxes (A and B). Sits between instruction decode and the EX-stage operand muxes, directly feeding their select inputs.

## Interface
- REG_W, 5: register-number width.
- CNT_W, 16: stall-counter width; used only with STALL_CNT_EN.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  source register A of the ID instruction.
- id_rt  in  REG_W  source register B of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rd  in  REG_W  final destination register, after the rd/rt destination mux.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- flush  in  1  kill the ID instruction (branch/jump redirect).
- stall  out  1  combinational; holds PC and IF/ID and injects a bubble into EX.
- fwd_a_sel  out  2  registered select for operand A mux.
- fwd_b_sel  out  2  registered select for operand B mux.
- ex_bubble  out  1  registered; EX holds a bubble.
- stall_cnt  out  CNT_W  only with STALL_CNT_EN.

## Operation
- Each tag stage (EX, MEM, WB, RET) holds rd, regwrite and memread. A tag is "live" when regwrite=1 and rd!=0.
- On every clock edge, RET<-WB, WB<-MEM and MEM<-EX unconditionally.
- EX receives the ID tag when id_valid & !flush & !stall. Otherwise EX receives a bubble: regwrite=0, memread=0, ex_bubble=1.
- stall = id_valid & !flush & EX live & ex_memread & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- Forward-select encoding is fixed to match the operand muxes:
  - 00: register file.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB result.
  - 11: RET-stage result buffer (covers same-cycle register-file write/read).
- Selects are computed for the instruction entering EX, using pre-edge tags. Priority, youngest first:
  - EX tag live and equal -> 01.
  - else MEM tag live and equal -> 10.
  - else WB tag live and equal -> 11.
  - else 00.
- A select is only non-zero when the corresponding id_use_* bit is set.
- When EX loads a bubble, both selects load 00.
- Register 0 is never forwarded, regardless of any tag.
- After a load-use stall, the load sits in WB when the consumer reaches EX, so the consumer gets select 10. A load is never forwarded with 01.

## Timing
- Reset values: all tags cleared (regwrite=0, memread=0, rd=0); fwd_a_sel=00, fwd_b_sel=00; ex_bubble=1; stall=0; stall_cnt=0.
- Reset mid-operation clears everything asynchronously. stall deasserts immediately because no tag is live.
- stall is combinational from ID inputs and the EX tag, and is valid in the same cycle.
- Selects and ex_bubble are registered: valid for the whole cycle the instruction occupies EX, with one-edge latency from ID.
- A load-use hazard costs exactly one stall cycle. The next cycle the load tag is in MEM, so stall cannot re-trigger on the same load.
- flush and a hazard in the same cycle: flush wins; stall=0 and a bubble enters EX.
- id_valid=0 gives stall=0 and a bubble into EX.
- Rs and rt are compared independently; both may forward from different stages in the same cycle.

## Configuration
- STALL_CNT_EN defined:
  - stall_cnt counts cycles with stall=1.
  - Saturates at 2^CNT_W-1.
  - Cleared by rst.
- STALL_CNT_EN undefined: stall_cnt port and counter are absent.

## Test plan
- ALU back-to-back: add $3 writes, next instruction reads rs=$3 -> stall=0; when the consumer is in EX, fwd_a_sel=01.
- Load-use: lw $5, next instruction reads rt=$5 -> stall=1 for exactly one cycle; ex_bubble=1 the following cycle; consumer in EX gets fwd_b_sel=10.
- Distance 3: producer $7, two independent instructions, then a reader of $7 on both rs and rt -> fwd_a_sel=11 and fwd_b_sel=11.
- Zero register / priority: writes to $0 ahead of a reader of $0 -> selects 00. Writes to $4 at distance 1 and 2 -> select 01 (youngest wins).
- Flush and stall together: load-use condition with flush=1 -> stall=0 and bubble in EX. With STALL_CNT_EN, stall_cnt unchanged.
- Reset mid-stall: assert rst while stall=1 -> stall=0, selects 00 and ex_bubble=1 immediately; stall_cnt=0.

Source files
------------

// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if
//   Groups the ID-stage hazard inputs and the EX operand-mux controls that
//   pass between instruction decode and hazard_fwd_unit.
//   master : decode side, drives the ID instruction fields and flush,
//            receives stall and the EX mux controls.
//   slave  : hazard_fwd_unit side.
//   Signals: id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
//            id_regwrite, id_memread, flush (decode -> unit);
//            stall, fwd_a_sel, fwd_b_sel, ex_bubble (unit -> decode/EX).
interface hazard_fwd_unit_if #(
  parameter int unsigned REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             ex_bubble;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, flush,
    input  stall, fwd_a_sel, fwd_b_sel, ex_bubble
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, flush,
    output stall, fwd_a_sel, fwd_b_sel, ex_bubble
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Load-use hazard detection and EX operand-forwarding select generation
//   for the 5-stage pipeline. Destination tags of in-flight instructions
//   advance EX -> MEM -> WB every clock; the instruction in ID is compared
//   against them to produce the stall and the registered mux selects.
//   Ports:
//     clk        pipeline clock, rising edge
//     rst        asynchronous, active-high reset
//     bus        hazard_fwd_unit_if.slave (ID fields, flush, stall,
//                fwd_a_sel, fwd_b_sel, ex_bubble)
//     stall_cnt  saturating count of stall cycles (STALL_CNT_EN only)
//   Select encoding: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 RET buffer.
//   Optional feature macro: STALL_CNT_EN adds the stall_cnt port/counter.
module hazard_fwd_unit #(
  parameter int unsigned REG_W = 5
`ifdef STALL_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input logic               clk,
  input logic               rst,
  hazard_fwd_unit_if.slave  bus
`ifdef STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Only EX needs memread (load-use check). A WB-stage match selects the
  // RET buffer (11) because that result sits in RET after the edge, so no
  // tag register behind WB is ever compared and none is kept.
  logic [REG_W-1:0] ex_rd_q,  ex_rd_d;
  logic             ex_rw_q,  ex_rw_d;
  logic             ex_mr_q,  ex_mr_d;
  logic [REG_W-1:0] mem_rd_q;
  logic             mem_rw_q;
  logic [REG_W-1:0] wb_rd_q;
  logic             wb_rw_q;
  logic [1:0]       sel_a_q,  sel_a_d;
  logic [1:0]       sel_b_q,  sel_b_d;
  logic             bub_q,    bub_d;

  logic ex_live, mem_live, wb_live;
  logic rs_hit, rt_hit;
  logic stall_c, issue;

  function automatic logic [1:0] fwd_sel(
    input logic             use_r,
    input logic [REG_W-1:0] r,
    input logic             exl,
    input logic [REG_W-1:0] exr,
    input logic             meml,
    input logic [REG_W-1:0] memr,
    input logic             wbl,
    input logic [REG_W-1:0] wbr
  );
    fwd_sel = 2'b00;
    if (use_r && (r != '0)) begin
      if (exl && (exr == r))        fwd_sel = 2'b01;
      else if (meml && (memr == r)) fwd_sel = 2'b10;
      else if (wbl && (wbr == r))   fwd_sel = 2'b11;
    end
  endfunction

  always_comb begin
    ex_live  = ex_rw_q  && (ex_rd_q  != '0);
    mem_live = mem_rw_q && (mem_rd_q != '0);
    wb_live  = wb_rw_q  && (wb_rd_q  != '0);
    rs_hit   = bus.id_use_rs && (bus.id_rs == ex_rd_q);
    rt_hit   = bus.id_use_rt && (bus.id_rt == ex_rd_q);
    stall_c  = bus.id_valid && !bus.flush && ex_live && ex_mr_q && (rs_hit || rt_hit);
    issue    = bus.id_valid && !bus.flush && !stall_c;

    ex_rd_d = '0;
    ex_rw_d = 1'b0;
    ex_mr_d = 1'b0;
    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
    bub_d   = 1'b1;
    if (issue) begin
      ex_rd_d = bus.id_rd;
      ex_rw_d = bus.id_regwrite;
      ex_mr_d = bus.id_memread;
      sel_a_d = fwd_sel(bus.id_use_rs, bus.id_rs, ex_live, ex_rd_q,
                        mem_live, mem_rd_q, wb_live, wb_rd_q);
      sel_b_d = fwd_sel(bus.id_use_rt, bus.id_rt, ex_live, ex_rd_q,
                        mem_live, mem_rd_q, wb_live, wb_rd_q);
      bub_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd_q  <= '0;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_rw_q  <= 1'b0;
      sel_a_q  <= 2'b00;
      sel_b_q  <= 2'b00;
      bub_q    <= 1'b1;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      mem_rd_q <= ex_rd_q;
      mem_rw_q <= ex_rw_q;
      wb_rd_q  <= mem_rd_q;
      wb_rw_q  <= mem_rw_q;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      bub_q    <= bub_d;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.fwd_a_sel = sel_a_q;
  assign bus.fwd_b_sel = sel_b_q;
  assign bus.ex_bubble = bub_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall_c && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
//   Directed pipeline scenarios with literal expectations, then randomized
//   instruction streams checked every cycle against a tag-history model.
module tb_hazard_fwd_unit;

  logic clk;
  logic rst;

  hazard_fwd_unit_if #(.REG_W(5)) bus ();

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
  hazard_fwd_unit #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt)
  );
`else
  hazard_fwd_unit #(.REG_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: index 0 = EX, 1 = MEM, 2 = WB (older entries at higher index).
  logic [4:0] m_rd [0:2];
  logic       m_wr [0:2];
  logic       m_ld [0:2];
  logic [1:0] m_sa, m_sb;
  logic       m_bub;
`ifdef STALL_CNT_EN
  logic [15:0] m_cnt;
`endif

  function automatic logic model_stall();
    logic hit;
    hit = (bus.id_use_rs && bus.id_rs == m_rd[0]) ||
          (bus.id_use_rt && bus.id_rt == m_rd[0]);
    return bus.id_valid && !bus.flush && m_ld[0] && m_wr[0] &&
           (m_rd[0] != 5'd0) && hit;
  endfunction

  // Scan oldest to youngest so the youngest matching producer wins.
  function automatic logic [1:0] pick(input logic use_r, input logic [4:0] r);
    logic [1:0] s;
    s = 2'b00;
    if (use_r && r != 5'd0)
      for (int k = 2; k >= 0; k--)
        if (m_wr[k] && m_rd[k] == r) s = 2'(k + 1);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_rd[k] <= 5'd0; m_wr[k] <= 1'b0; m_ld[k] <= 1'b0;
      end
      m_sa  <= 2'b00;
      m_sb  <= 2'b00;
      m_bub <= 1'b1;
`ifdef STALL_CNT_EN
      m_cnt <= 16'd0;
`endif
    end else begin
      logic st, go;
      st = model_stall();
      go = bus.id_valid && !bus.flush && !st;
      m_sa  <= go ? pick(bus.id_use_rs, bus.id_rs) : 2'b00;
      m_sb  <= go ? pick(bus.id_use_rt, bus.id_rt) : 2'b00;
      m_bub <= !go;
      m_rd[2] <= m_rd[1]; m_wr[2] <= m_wr[1]; m_ld[2] <= m_ld[1];
      m_rd[1] <= m_rd[0]; m_wr[1] <= m_wr[0]; m_ld[1] <= m_ld[0];
      m_rd[0] <= go ? bus.id_rd : 5'd0;
      m_wr[0] <= go && bus.id_regwrite;
      m_ld[0] <= go && bus.id_memread;
`ifdef STALL_CNT_EN
      if (st && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("stall", 32'(bus.stall), 32'(model_stall()));
    chk("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(m_sa));
    chk("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(m_sb));
    chk("ex_bubble", 32'(bus.ex_bubble), 32'(m_bub));
`ifdef STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
  endtask

  // One cycle: compare on the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl);
    bus.id_valid = v;  bus.id_rs = rs; bus.id_rt = rt;
    bus.id_use_rs = urs; bus.id_use_rt = urt; bus.id_rd = rd;
    bus.id_regwrite = rw; bus.id_memread = mr; bus.flush = fl;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_sel_a"}, 32'(bus.fwd_a_sel), 32'd0);
    chk({tag, "_sel_b"}, 32'(bus.fwd_b_sel), 32'd0);
    chk({tag, "_bubble"}, 32'(bus.ex_bubble), 32'd1);
`ifdef STALL_CNT_EN
    chk({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // ALU back-to-back: add $3 then reader of rs=$3.
    set_id(1, 1, 2, 0, 0, 3, 1, 0, 0); tick();
    set_id(1, 3, 9, 1, 0, 12, 1, 0, 0); #1;
    chk("alu_b2b_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("alu_b2b_sel_a", 32'(bus.fwd_a_sel), 32'd1);
    chk("alu_b2b_bubble", 32'(bus.ex_bubble), 32'd0);

    // Load-use: lw $5 then reader of rt=$5.
    set_id(1, 1, 1, 0, 0, 5, 1, 1, 0); tick();
    set_id(1, 9, 5, 0, 1, 13, 1, 0, 0); #1;
    chk("loaduse_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("loaduse_bubble", 32'(bus.ex_bubble), 32'd1);
    chk("loaduse_stall_gone", 32'(bus.stall), 32'd0);
    tick();
    chk("loaduse_sel_b", 32'(bus.fwd_b_sel), 32'd2);

    // Distance 3: $7, two independent writers, reader of $7 on rs and rt.
    set_id(1, 0, 0, 0, 0, 7, 1, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 10, 1, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 11, 1, 0, 0); tick();
    set_id(1, 7, 7, 1, 1, 14, 1, 0, 0); tick();
    chk("dist3_sel_a", 32'(bus.fwd_a_sel), 32'd3);
    chk("dist3_sel_b", 32'(bus.fwd_b_sel), 32'd3);

    // Register 0 is never forwarded.
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    set_id(1, 0, 0, 1, 1, 15, 1, 0, 0); tick();
    chk("zero_sel_a", 32'(bus.fwd_a_sel), 32'd0);
    chk("zero_sel_b", 32'(bus.fwd_b_sel), 32'd0);

    // Youngest producer wins.
    set_id(1, 0, 0, 0, 0, 4, 1, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 4, 1, 0, 0); tick();
    set_id(1, 4, 0, 1, 0, 16, 1, 0, 0); tick();
    chk("prio_sel_a", 32'(bus.fwd_a_sel), 32'd1);

    // Flush beats a load-use hazard.
    set_id(1, 0, 0, 0, 0, 6, 1, 1, 0); tick();
    set_id(1, 6, 0, 1, 0, 17, 1, 0, 1); #1;
    chk("flush_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("flush_bubble", 32'(bus.ex_bubble), 32'd1);
    chk("flush_sel_a", 32'(bus.fwd_a_sel), 32'd0);

    // Reset while stalled.
    set_id(1, 0, 0, 0, 0, 8, 1, 1, 0); tick();
    set_id(1, 0, 8, 0, 1, 18, 1, 0, 0); #1;
    chk("rststall_pre", 32'(bus.stall), 32'd1);
    rst = 1'b1; #1;
    chk_reset_outputs("rststall");
    tick();
    rst = 1'b0;

    // Randomized streams over a small register range to provoke hazards.
    for (int unsigned i = 0; i < 3000; i++) begin
      set_id($urandom_range(0, 7) != 0,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             5'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; #1;
        chk_reset_outputs("rand_rst");
        #1 rst = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
